// File: rtl/window_fetcher.sv
// window_fetcher: accepts one window origin per hop handshake, reads the
// SWEEP_X x SWEEP_Y sub-window out of the row-major image buffer and streams
// the pixels in raster order, with window-relative coordinates, downstream.
//
// Handshakes: a transfer happens in a cycle where valid && ready are both 1.
// A producer holds valid (and its payload) until that transfer; the consumer
// may change ready at any time. This applies to hop_* and pix_*.
//
// Reads and pixels in flight are bounded to two. A read is issued only when
// the FIFO entries plus the read in flight, less this cycle's pop, is below
// two, so returning data always has a free FIFO slot.
module window_fetcher #(
   parameter  int IMG_WIDTH  = 41,
   parameter  int IMG_HEIGHT = 50,
   parameter  int SWEEP_X    = 24,
   parameter  int SWEEP_Y    = 24,
   parameter  int PIX_W      = 8,
   localparam int W_X        = $clog2(IMG_WIDTH),
   localparam int W_Y        = $clog2(IMG_HEIGHT),
   localparam int ADDR_W     = $clog2(IMG_WIDTH * IMG_HEIGHT),
   localparam int WX_W       = $clog2(SWEEP_X),
   localparam int WY_W       = $clog2(SWEEP_Y)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              hop_valid,
   output logic              hop_ready,
   input  logic [W_X-1:0]    x_hop,
   input  logic [W_Y-1:0]    y_hop,
   output logic              mem_rd,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [PIX_W-1:0]  mem_data,
   output logic              pix_valid,
   input  logic              pix_ready,
   output logic [PIX_W-1:0]  pix_data,
   output logic [WX_W-1:0]   pix_x,
   output logic [WY_W-1:0]   pix_y,
   output logic              pix_last,
   output logic              busy,
   output logic [1:0]        state_dbg
);

   typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, DRAIN = 2'd2} state_t;

   localparam int                E_W      = PIX_W + WX_W + WY_W + 1;
   localparam logic [ADDR_W-1:0] IMG_W_A  = ADDR_W'(IMG_WIDTH);
   localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_WIDTH - SWEEP_X + 1);
   localparam logic [WX_W-1:0]   WX_LAST  = WX_W'(SWEEP_X - 1);
   localparam logic [WY_W-1:0]   WY_LAST  = WY_W'(SWEEP_Y - 1);

   state_t              state;
   logic [ADDR_W-1:0]   rd_addr;
   logic [WX_W-1:0]     wx;
   logic [WY_W-1:0]     wy;

   // tag of the read in flight, aligned with mem_data in the next cycle
   logic                rd_q;
   logic [WX_W-1:0]     rd_wx;
   logic [WY_W-1:0]     rd_wy;
   logic                rd_last;

   // two-entry FIFO, head always in slot0
   logic [E_W-1:0]      slot0, slot1;
   logic [1:0]          count;
   logic [1:0]          count_next;
   logic [1:0]          occ;
   logic                push, pop, issue, issue_last;
   logic                head_last;
   logic [E_W-1:0]      new_entry;

   // handshake, issue and FIFO bookkeeping
   always_comb begin
      hop_ready  = !rst && (state == IDLE);
      pix_valid  = !rst && (count != 2'd0);
      pop        = pix_valid && pix_ready;
      push       = rd_q;
      occ        = count + {1'b0, rd_q};
      issue      = !rst && (state == FETCH) &&
                   ((occ < 2'd2) || ((occ == 2'd2) && pop));
      issue_last = (wx == WX_LAST) && (wy == WY_LAST);
      count_next = count + {1'b0, push} - {1'b0, pop};
      new_entry  = {mem_data, rd_wx, rd_wy, rd_last};
   end

   assign mem_rd    = issue;
   assign mem_addr  = rd_addr;
   assign busy      = (state != IDLE);
   assign state_dbg = state;
   assign {pix_data, pix_x, pix_y, head_last} = slot0;
   assign pix_last  = pix_valid && head_last;

   // window FSM: origin latch, raster read walk, drain to idle
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         rd_addr <= '0;
         wx      <= '0;
         wy      <= '0;
         rd_q    <= 1'b0;
         rd_wx   <= '0;
         rd_wy   <= '0;
         rd_last <= 1'b0;
      end else begin
         rd_q    <= issue;
         rd_wx   <= wx;
         rd_wy   <= wy;
         rd_last <= issue_last;
         case (state)
            IDLE: begin
               if (hop_valid) begin
                  rd_addr <= ADDR_W'(y_hop) * IMG_W_A + ADDR_W'(x_hop);
                  wx      <= '0;
                  wy      <= '0;
                  state   <= FETCH;
               end
            end
            FETCH: begin
               if (issue) begin
                  if (wx == WX_LAST) begin
                     wx      <= '0;
                     wy      <= wy + 1'b1;
                     rd_addr <= rd_addr + ROW_STEP;
                  end else begin
                     wx      <= wx + 1'b1;
                     rd_addr <= rd_addr + 1'b1;
                  end
                  if (issue_last) state <= DRAIN;
               end
            end
            DRAIN: begin
               if (!rd_q && (count_next == 2'd0)) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // output FIFO: push returning read data, pop on pixel transfer
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= 2'd0;
         slot0 <= '0;
         slot1 <= '0;
      end else begin
         count <= count_next;
         case ({push, pop})
            2'b10: begin
               if (count == 2'd0) slot0 <= new_entry;
               else               slot1 <= new_entry;
            end
            2'b01: slot0 <= slot1;
            2'b11: begin
               if (count == 2'd1) begin
                  slot0 <= new_entry;
               end else begin
                  slot0 <= slot1;
                  slot1 <= new_entry;
               end
            end
            default: ;
         endcase
      end
   end

`ifndef SYNTHESIS
   localparam logic [W_X-1:0] X_MAX = W_X'(IMG_WIDTH - SWEEP_X);
   localparam logic [W_Y-1:0] Y_MAX = W_Y'(IMG_HEIGHT - SWEEP_Y);

   // flag accepted origins whose window would leave the image
   always_ff @(posedge clk) begin
      if (hop_valid && hop_ready)
         assert ((x_hop <= X_MAX) && (y_hop <= Y_MAX))
            else $error("window origin out of range");
   end
`endif

endmodule
